// File: rtl/pipeline_run_ctrl.sv
// Run/step sequencer for the five-stage pipeline: drives the stage-latch enables,
// drains in-flight instructions after HALT and counts executed cycles.
// Optional RUN watchdog is compiled in when RUN_CTRL_WATCHDOG_EN is defined.
module pipeline_run_ctrl #(
   parameter int          DRAIN_CYCLES = 4,
   parameter int          CYCLE_W      = 32,
   parameter logic [31:0] MAX_CYCLES   = 32'd1_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_code,
   input  logic               halt_instr,
   output logic               enable,
   output logic               enablePc,
   output logic [2:0]         state,
   output logic [CYCLE_W-1:0] cycle_count,
   output logic               done,
   output logic               timeout
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_PAUSE = 2'b11;

   localparam logic [3:0]         DRAIN_LOAD = 4'(DRAIN_CYCLES);
   localparam logic [CYCLE_W-1:0] COUNT_ONE  = CYCLE_W'(1);
   localparam logic [CYCLE_W-1:0] COUNT_MAX  = '1;

   state_t     cur_state;
   state_t     nxt_state;
   logic [3:0] drain_cnt;
   logic       accept;
   logic       wd_hit;

   assign accept = cmd_valid & cmd_ready;
   assign state  = cur_state;

   // State register plus the drain, cycle and done bookkeeping that follows it
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state   <= ST_IDLE;
         drain_cnt   <= 4'd0;
         cycle_count <= '0;
         done        <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         done      <= (nxt_state == ST_HALTED) && (cur_state != ST_HALTED);
         if (enablePc && (cycle_count != COUNT_MAX)) begin
            cycle_count <= cycle_count + COUNT_ONE;
         end
         if ((nxt_state == ST_DRAIN) && (cur_state != ST_DRAIN)) begin
            drain_cnt <= DRAIN_LOAD;
         end else if (cur_state == ST_DRAIN) begin
            drain_cnt <= drain_cnt - 4'd1;
         end
      end
   end

`ifdef RUN_CTRL_WATCHDOG_EN
   logic [31:0] wd_cnt;

   assign wd_hit = (wd_cnt == (MAX_CYCLES - 32'd1));

   // Counts consecutive RUN cycles; a HALT in the same cycle outranks the timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt  <= 32'd0;
         timeout <= 1'b0;
      end else begin
         if ((nxt_state == ST_RUN) && (cur_state != ST_RUN)) begin
            wd_cnt <= 32'd0;
         end else if (cur_state == ST_RUN) begin
            wd_cnt <= wd_cnt + 32'd1;
         end
         if ((cur_state == ST_RUN) && wd_hit && !halt_instr) begin
            timeout <= 1'b1;
         end
      end
   end
`else
   assign wd_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   // Next-state decode; halt_instr only matters while the PC is advancing
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         ST_IDLE: begin
            if (accept && (cmd_code == CMD_RUN)) begin
               nxt_state = ST_RUN;
            end else if (accept && (cmd_code == CMD_STEP)) begin
               nxt_state = ST_STEP;
            end
         end
         ST_RUN: begin
            if (halt_instr) begin
               nxt_state = ST_DRAIN;
            end else if (wd_hit) begin
               nxt_state = ST_IDLE;
            end else if (accept && (cmd_code == CMD_PAUSE)) begin
               nxt_state = ST_IDLE;
            end
         end
         ST_STEP: begin
            nxt_state = halt_instr ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (drain_cnt == 4'd1) begin
               nxt_state = ST_HALTED;
            end
         end
         ST_HALTED: begin
            nxt_state = ST_HALTED;
         end
         default: begin
            nxt_state = ST_IDLE;
         end
      endcase
   end

   // Outputs come from the state register alone, so inputs never reach them combinationally
   always_comb begin
      enable    = 1'b0;
      enablePc  = 1'b0;
      cmd_ready = 1'b0;
      case (cur_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
         end
         ST_RUN: begin
            enable    = 1'b1;
            enablePc  = 1'b1;
            cmd_ready = 1'b1;
         end
         ST_STEP: begin
            enable   = 1'b1;
            enablePc = 1'b1;
         end
         ST_DRAIN: begin
            enable = 1'b1;
         end
         ST_HALTED: begin
            cmd_ready = 1'b1;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed command/halt sequences checked against a
// cycle-level behavioural model plus literal expectations for the key scenarios.
module tb_pipeline_run_ctrl;

   localparam int          DRAIN_CYCLES = 4;
   localparam int          CYCLE_W      = 6;
   localparam logic [31:0] MAX_CYCLES   = 32'd16;
   localparam int          COUNT_MAX    = (1 << CYCLE_W) - 1;

   localparam logic [1:0] NOP   = 2'b00;
   localparam logic [1:0] RUN   = 2'b01;
   localparam logic [1:0] STEP  = 2'b10;
   localparam logic [1:0] PAUSE = 2'b11;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [1:0]         cmd_code = 2'b00;
   logic               halt_instr = 1'b0;
   logic               enable;
   logic               enablePc;
   logic [2:0]         state;
   logic [CYCLE_W-1:0] cycle_count;
   logic               done;
   logic               timeout;

   int errors = 0;
   int checks = 0;

   pipeline_run_ctrl #(
      .DRAIN_CYCLES(DRAIN_CYCLES),
      .CYCLE_W     (CYCLE_W),
      .MAX_CYCLES  (MAX_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_code   (cmd_code),
      .halt_instr (halt_instr),
      .enable     (enable),
      .enablePc   (enablePc),
      .state      (state),
      .cycle_count(cycle_count),
      .done       (done),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   // Behavioural model: state as a plain number, counters as integers
   int m_state = 0;
   int m_drain_left = 0;
   int m_count = 0;
   int m_done = 0;
   int m_timeout = 0;
   int m_run_cycles = 0;
   bit model_valid = 1'b0;

   function automatic bit readyIn(input int s);
      return (s == 0) || (s == 1) || (s == 4);
   endfunction

   always @(posedge clk) begin
      int prev;
      bit take;
      if (reset) begin
         m_state = 0;
         m_drain_left = 0;
         m_count = 0;
         m_done = 0;
         m_timeout = 0;
         m_run_cycles = 0;
         model_valid = 1'b1;
      end else begin
         prev = m_state;
         take = cmd_valid && readyIn(prev);
         if ((prev == 1 || prev == 2) && m_count < COUNT_MAX) m_count = m_count + 1;
         if (prev == 0) begin
            if (take && cmd_code == RUN) begin
               m_state = 1;
               m_run_cycles = 0;
            end else if (take && cmd_code == STEP) begin
               m_state = 2;
            end
         end else if (prev == 1) begin
            bit wd_expired;
            wd_expired = 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
            wd_expired = (m_run_cycles == int'(MAX_CYCLES) - 1);
`endif
            if (halt_instr) begin
               m_state = 3;
               m_drain_left = DRAIN_CYCLES;
            end else if (wd_expired) begin
               m_state = 0;
               m_timeout = 1;
            end else if (take && cmd_code == PAUSE) begin
               m_state = 0;
            end else begin
               m_run_cycles = m_run_cycles + 1;
            end
         end else if (prev == 2) begin
            if (halt_instr) begin
               m_state = 3;
               m_drain_left = DRAIN_CYCLES;
            end else begin
               m_state = 0;
            end
         end else if (prev == 3) begin
            m_drain_left = m_drain_left - 1;
            if (m_drain_left == 0) m_state = 4;
         end
         m_done = (m_state == 4 && prev != 4) ? 1 : 0;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("state", int'(state), m_state);
         checkOutput("enable", int'(enable), (m_state >= 1 && m_state <= 3) ? 1 : 0);
         checkOutput("enablePc", int'(enablePc), (m_state == 1 || m_state == 2) ? 1 : 0);
         checkOutput("cmd_ready", int'(cmd_ready), readyIn(m_state) ? 1 : 0);
         checkOutput("cycle_count", int'(cycle_count), m_count);
         checkOutput("done", int'(done), m_done);
         checkOutput("timeout", int'(timeout), m_timeout);
      end
   end

   task automatic applyStimulus(input logic v, input logic [1:0] code, input logic h);
      cmd_valid  = v;
      cmd_code   = code;
      halt_instr = h;
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, NOP, 1'b0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, NOP, 1'b0);
      applyStimulus(1'b0, NOP, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      doReset();
      checkOutput("rst_state", int'(state), 0);
      checkOutput("rst_enable", int'(enable), 0);
      checkOutput("rst_count", int'(cycle_count), 0);
      checkOutput("rst_ready", int'(cmd_ready), 1);
      checkOutput("rst_timeout", int'(timeout), 0);

      applyStimulus(1'b1, NOP, 1'b0);
      applyStimulus(1'b1, PAUSE, 1'b0);
      checkOutput("idle_nop_pause", int'(state), 0);

      // single STEP, with a RUN offered while STEP holds cmd_ready low
      applyStimulus(1'b1, STEP, 1'b0);
      checkOutput("step_state", int'(state), 2);
      checkOutput("step_enablePc", int'(enablePc), 1);
      checkOutput("step_ready", int'(cmd_ready), 0);
      applyStimulus(1'b1, RUN, 1'b0);
      checkOutput("step_back_idle", int'(state), 0);
      checkOutput("step_count", int'(cycle_count), 1);
      applyStimulus(1'b0, NOP, 1'b0);

      // RUN then PAUSE on the tenth cycle
      doReset();
      applyStimulus(1'b1, RUN, 1'b0);
      idleCycles(9);
      applyStimulus(1'b1, PAUSE, 1'b0);
      checkOutput("pause_state", int'(state), 0);
      checkOutput("pause_enable", int'(enable), 0);
      checkOutput("pause_count", int'(cycle_count), 10);

`ifndef RUN_CTRL_WATCHDOG_EN
      // HALT at cycle 20 and drain
      doReset();
      applyStimulus(1'b1, RUN, 1'b0);
      idleCycles(19);
      applyStimulus(1'b0, NOP, 1'b1);
      checkOutput("halt_drain", int'(state), 3);
      checkOutput("halt_enablePc", int'(enablePc), 0);
      checkOutput("halt_enable", int'(enable), 1);
      idleCycles(3);
      checkOutput("drain_last", int'(state), 3);
      checkOutput("drain_no_done", int'(done), 0);
      applyStimulus(1'b0, NOP, 1'b1);
      checkOutput("halted_state", int'(state), 4);
      checkOutput("halted_done", int'(done), 1);
      checkOutput("halted_count", int'(cycle_count), 20);
      applyStimulus(1'b1, RUN, 1'b0);
      checkOutput("halted_done_drop", int'(done), 0);
      checkOutput("halted_sticky", int'(state), 4);
      idleCycles(2);
`endif

      // STEP onto a HALT goes to DRAIN; halt seen in IDLE is ignored
      doReset();
      applyStimulus(1'b1, STEP, 1'b1);
      checkOutput("step_halt_ignored_idle", int'(state), 2);
      applyStimulus(1'b0, NOP, 1'b1);
      checkOutput("step_halt_drain", int'(state), 3);
      idleCycles(5);
      checkOutput("step_halt_halted", int'(state), 4);

      // PAUSE and HALT together in RUN, then reset mid-DRAIN
      doReset();
      applyStimulus(1'b1, RUN, 1'b0);
      idleCycles(2);
      applyStimulus(1'b1, PAUSE, 1'b1);
      checkOutput("pause_halt_drain", int'(state), 3);
      idleCycles(2);
      reset = 1'b1;
      applyStimulus(1'b0, NOP, 1'b0);
      reset = 1'b0;
      checkOutput("mid_drain_reset_state", int'(state), 0);
      checkOutput("mid_drain_reset_enable", int'(enable), 0);
      checkOutput("mid_drain_reset_count", int'(cycle_count), 0);
      idleCycles(8);
      checkOutput("no_late_done", int'(done), 0);
      checkOutput("no_late_state", int'(state), 0);

`ifndef RUN_CTRL_WATCHDOG_EN
      // cycle counter saturates instead of wrapping
      doReset();
      applyStimulus(1'b1, RUN, 1'b0);
      idleCycles(70);
      applyStimulus(1'b1, PAUSE, 1'b0);
      checkOutput("count_saturate", int'(cycle_count), COUNT_MAX);
      checkOutput("no_timeout", int'(timeout), 0);
`else
      doReset();
      applyStimulus(1'b1, RUN, 1'b0);
      idleCycles(15);
      checkOutput("wd_still_run", int'(state), 1);
      applyStimulus(1'b0, NOP, 1'b0);
      checkOutput("wd_state", int'(state), 0);
      checkOutput("wd_timeout", int'(timeout), 1);
      checkOutput("wd_count", int'(cycle_count), 16);
`endif

      idleCycles(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
